filter_spad_writer: RTL and testbench

- PE-side receiving end of the filter delivery path. Accepts the tagged filter-word stream that the NoC controller's filter index generator drives onto the row bus.
- Keeps only words whose row tag matches this PE's row. Writes them into the PE filter scratchpad in (col, channel, filter) order.
- Reports completion once one full pass of p*q*S words has been stored.
- Sits between the horizontal filter bus and the filter spad in every PE.

---
 rtl/filter_spad_writer.sv | 157 +++++++++++++++
 tb/tb_filter_spad_writer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/filter_spad_writer.sv
// Purpose: PE-side filter bus receiver. Keeps row-matched words and writes them to the filter spad in (col, channel, filter) order.
// Latency: a matched word is written to the spad 1 cycle after acceptance; done pulses 1 cycle after the final write.
// Backpressure: await = stall | !LOAD, so words are taken only in LOAD while the spad port is free.
module filter_spad_writer #(
  parameter int DATA_WIDTH = 16,
  parameter int R_WIDTH    = 4,
  parameter int S_WIDTH    = 6,
  parameter int p_WIDTH    = 5,
  parameter int q_WIDTH    = 3,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [S_WIDTH-1:0]    S,
  input  logic [p_WIDTH-1:0]    p,
  input  logic [q_WIDTH-1:0]    q,
  input  logic [R_WIDTH-1:0]    pe_row,
  input  logic                  stall,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [R_WIDTH-1:0]    in_row,
  output logic                  await,
  output logic                  spad_we,
  output logic [ADDR_WIDTH-1:0] spad_addr,
  output logic [DATA_WIDTH-1:0] spad_wdata,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  // Wide enough to hold s*p*q + q*p + p for any legal config without overflow.
  localparam int FULL_W = S_WIDTH + p_WIDTH + q_WIDTH + 1;

  state_t state;

  // Config captured at start; the live inputs may change freely during a pass.
  logic [S_WIDTH-1:0] s_lat;
  logic [p_WIDTH-1:0] p_lat;
  logic [q_WIDTH-1:0] q_lat;
  logic [R_WIDTH-1:0] row_lat;

  // Position of the next matched word inside the pass.
  logic [S_WIDTH-1:0] s_cnt;
  logic [p_WIDTH-1:0] p_cnt;
  logic [q_WIDTH-1:0] q_cnt;

  logic              accept;
  logic              match;
  logic              p_last;
  logic              q_last;
  logic              s_last;
  logic              pass_last;
  logic [FULL_W-1:0] addr_full;

  // The bus may only push a word while we are loading and the spad port is free.
  assign await  = stall | (state != LOAD);
  assign accept = (state == LOAD) & in_valid & ~await;
  assign match  = accept & (in_row == row_lat);

  assign p_last    = (p_cnt == (p_lat - p_WIDTH'(1)));
  assign q_last    = (q_cnt == (q_lat - q_WIDTH'(1)));
  assign s_last    = (s_cnt == (s_lat - S_WIDTH'(1)));
  assign pass_last = p_last & q_last & s_last;

  // Layout is column-major over (col, channel, filter); oversized configs simply wrap in the spad.
  assign addr_full = (FULL_W'(s_cnt) * FULL_W'(p_lat) * FULL_W'(q_lat))
                   + (FULL_W'(q_cnt) * FULL_W'(p_lat))
                   + FULL_W'(p_cnt);

  // Control FSM with registered busy/done; LOAD->DONE happens on the edge that takes the last word.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      s_lat   <= '0;
      p_lat   <= '0;
      q_lat   <= '0;
      row_lat <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            s_lat   <= S;
            p_lat   <= p;
            q_lat   <= q;
            row_lat <= pe_row;
            state   <= LOAD;
            busy    <= 1'b1;
          end
        end
        LOAD: begin
          if (match && pass_last) begin
            state <= DONE;
            busy  <= 1'b0;
          end
        end
        DONE: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Nested position counters: filter index fastest, then channel, then column.
  always_ff @(posedge clk) begin
    if (reset) begin
      p_cnt <= '0;
      q_cnt <= '0;
      s_cnt <= '0;
    end else if (match) begin
      if (p_last) begin
        p_cnt <= '0;
        if (q_last) begin
          q_cnt <= '0;
          if (s_last) begin
            s_cnt <= '0;
          end else begin
            s_cnt <= s_cnt + S_WIDTH'(1);
          end
        end else begin
          q_cnt <= q_cnt + q_WIDTH'(1);
        end
      end else begin
        p_cnt <= p_cnt + p_WIDTH'(1);
      end
    end
  end

  // Registered spad write port; reset drops any write that was about to issue.
  always_ff @(posedge clk) begin
    if (reset) begin
      spad_we    <= 1'b0;
      spad_addr  <= '0;
      spad_wdata <= '0;
    end else begin
      spad_we <= match;
      if (match) begin
        spad_addr  <= ADDR_WIDTH'(addr_full);
        spad_wdata <= in_data;
      end
    end
  end

endmodule

// File: tb/tb_filter_spad_writer.sv
// Bench for filter_spad_writer: scoreboard of expected spad writes and done pulses.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Expected writes are queued at the accepting cycle and matched by address, data and cycle stamp.
module tb_filter_spad_writer;

  localparam int DW = 16;
  localparam int RW = 4;
  localparam int SW = 6;
  localparam int PW = 5;
  localparam int QW = 3;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [SW-1:0] S;
  logic [PW-1:0] p;
  logic [QW-1:0] q;
  logic [RW-1:0] pe_row;
  logic          stall;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic [RW-1:0] in_row;
  logic          await;
  logic          spad_we;
  logic [AW-1:0] spad_addr;
  logic [DW-1:0] spad_wdata;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  filter_spad_writer #(
    .DATA_WIDTH(DW), .R_WIDTH(RW), .S_WIDTH(SW),
    .p_WIDTH(PW), .q_WIDTH(QW), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .S(S), .p(p), .q(q), .pe_row(pe_row),
    .stall(stall), .in_valid(in_valid), .in_data(in_data), .in_row(in_row),
    .await(await), .spad_we(spad_we), .spad_addr(spad_addr), .spad_wdata(spad_wdata),
    .busy(busy), .done(done)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            cyc;
  } wr_t;

  wr_t sb[$];
  int  done_q[$];
  int  n_cmp = 0;
  int  n_mis = 0;
  int  cyc = 0;
  int  exp_n = 0;
  int  pass_len = 0;
  logic [RW-1:0] cur_row = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Check every observed write and done pulse against the scoreboard.
  always @(negedge clk) begin
    if (spad_we === 1'b1) begin
      chk_eq("wr_pending", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        wr_t e;
        e = sb.pop_front();
        chk_eq("wr_addr", 32'(spad_addr), 32'(e.addr));
        chk_eq("wr_data", 32'(spad_wdata), 32'(e.data));
        chk_eq("wr_cyc", 32'(cyc), 32'(e.cyc));
      end
    end
    if (done === 1'b1) begin
      chk_eq("done_pending", 32'(done_q.size() != 0), 32'd1);
      if (done_q.size() != 0) chk_eq("done_cyc", 32'(cyc), 32'(done_q.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int s_v, input int p_v, input int q_v, input int row_v);
    S = SW'(s_v); p = PW'(p_v); q = QW'(q_v); pe_row = RW'(row_v);
    start = 1'b1;
    tick();
    start = 1'b0;
    // Scramble live config: the DUT must keep using the latched values.
    S = SW'(1); p = PW'(1); q = QW'(1); pe_row = ~RW'(row_v);
    exp_n = 0;
    pass_len = s_v * p_v * q_v;
    cur_row = RW'(row_v);
    @(negedge clk);
    chk_eq("busy_after_start", 32'(busy), 32'd1);
    tick();
  endtask

  // Present one word, wait (bounded) until it is accepted, and queue its expected effects.
  task automatic send(input logic [DW-1:0] d, input logic [RW-1:0] r);
    int n;
    logic [AW-1:0] a;
    n = 0;
    in_valid = 1'b1; in_data = d; in_row = r;
    @(negedge clk);
    while (await !== 1'b0 && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk_eq("accept_wait", 32'(await), 32'd0);
    chk_eq("busy_on_accept", 32'(busy), 32'd1);
    if (r == cur_row) begin
      a = exp_n[AW-1:0];
      sb.push_back('{addr: a, data: d, cyc: cyc + 1});
      exp_n++;
      if (exp_n == pass_len) begin
        done_q.push_back(cyc + 2);
        exp_n = 0;
      end
    end
    tick();
  endtask

  task automatic finish_pass(input string tag);
    in_valid = 1'b0;
    repeat (4) tick();
    chk_eq({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
    chk_eq({tag, "_done_seen"}, 32'(done_q.size()), 32'd0);
    chk_eq({tag, "_busy_low"}, 32'(busy), 32'd0);
    chk_eq({tag, "_await_idle"}, 32'(await), 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit 400000");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; S = '0; p = '0; q = '0; pe_row = '0;
    stall = 1'b0; in_valid = 1'b0; in_data = '0; in_row = '0;
    repeat (3) tick();
    @(negedge clk);
    chk_eq("rst_we", 32'(spad_we), 32'd0);
    chk_eq("rst_addr", 32'(spad_addr), 32'd0);
    chk_eq("rst_wdata", 32'(spad_wdata), 32'd0);
    chk_eq("rst_busy", 32'(busy), 32'd0);
    chk_eq("rst_done", 32'(done), 32'd0);
    chk_eq("rst_await", 32'(await), 32'd1);
    tick();
    reset = 1'b0;

    // Words in IDLE must be ignored.
    in_valid = 1'b1; in_data = 16'hDEAD; in_row = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk_eq("idle_await", 32'(await), 32'd1);
      chk_eq("idle_we", 32'(spad_we), 32'd0);
      tick();
    end
    in_valid = 1'b0;

    // Basic pass, with a redundant start pulsed mid-LOAD.
    do_start(3, 2, 2, 1);
    for (int i = 0; i < 12; i++) begin
      if (i == 6) start = 1'b1;
      send(DW'(16'h100 + i), RW'(1));
      start = 1'b0;
    end
    finish_pass("basic");

    // Row filtering: alternating tags 0 and 1.
    do_start(3, 2, 2, 1);
    for (int i = 0; i < 24; i++) send(DW'(16'h300 + i), RW'(i % 2));
    finish_pass("filter");

    // Address order with a different shape.
    do_start(2, 3, 2, 0);
    for (int i = 0; i < 12; i++) send(DW'(16'h400 + i), RW'(0));
    finish_pass("order");

    // Stall for 3 cycles after word 4 with the next word held on the bus.
    do_start(3, 2, 2, 2);
    for (int i = 0; i < 5; i++) send(DW'(16'h500 + i), RW'(2));
    in_valid = 1'b1; in_data = 16'h505; in_row = RW'(2); stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_eq("stall_await", 32'(await), 32'd1);
      chk_eq("stall_busy", 32'(busy), 32'd1);
      if (i > 0) chk_eq("stall_we", 32'(spad_we), 32'd0);
      tick();
    end
    stall = 1'b0;
    for (int i = 5; i < 12; i++) send(DW'(16'h500 + i), RW'(2));
    finish_pass("stall");

    // Reset mid-pass, coincident with a 6th word so its write is cancelled.
    do_start(3, 2, 2, 1);
    for (int i = 0; i < 5; i++) send(DW'(16'h600 + i), RW'(1));
    in_valid = 1'b1; in_data = 16'h6FF; in_row = RW'(1); reset = 1'b1;
    tick();
    reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk_eq("midrst_we", 32'(spad_we), 32'd0);
    chk_eq("midrst_await", 32'(await), 32'd1);
    chk_eq("midrst_busy", 32'(busy), 32'd0);
    tick();
    chk_eq("midrst_sb", 32'(sb.size()), 32'd0);
    do_start(3, 2, 2, 1);
    for (int i = 0; i < 12; i++) send(DW'(16'h700 + i), RW'(1));
    finish_pass("after_rst");

    // Oversized pass: 280 words wrap the 256-entry address space.
    do_start(5, 8, 7, 3);
    for (int i = 0; i < 280; i++) send(DW'(16'h8000 + i), RW'(3));
    finish_pass("wrap");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
